// File: rtl/decoder_pkg.sv
// Shared constants and the reference one-hot function for the decoder slice.
// Holds the legal select-width range and the default width.
package decoder_pkg;

  localparam int DEC_N_MIN     = 1;
  localparam int DEC_N_MAX     = 6;
  localparam int DEC_N_DEFAULT = 2;
  localparam int DEC_M_MAX     = 1 << DEC_N_MAX;

  // Returns a one-hot vector at the widest legal size.
  // Callers cast the result down to their own M.
  function automatic logic [DEC_M_MAX-1:0] dec_onehot(input logic [DEC_N_MAX-1:0] code);
    logic [DEC_M_MAX-1:0] r;
    r = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Purely combinational binary-to-one-hot decode of an N-bit select code.
// Contains no clock, enable or polarity handling.
module decoder_core
  import decoder_pkg::*;
#(
  parameter  int N = DEC_N_DEFAULT,
  localparam int M = 1 << N
) (
  input  logic [N-1:0] d,
  output logic [M-1:0] onehot
);

  always_comb begin
    onehot = M'(dec_onehot(DEC_N_MAX'(d)));
  end

endmodule

// File: rtl/decoder.sv
// Registered one-hot decoder with enable, valid flag and optional active-low output.
// Macro DECODER_HOLD_EN: when defined, en=0 holds the last decode instead of clearing it.
module decoder
  import decoder_pkg::*;
#(
  parameter  int N          = DEC_N_DEFAULT,
  parameter  bit ACTIVE_LOW = 1'b0,
  localparam int M          = 1 << N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         en,
  output logic [M-1:0] y,
  output logic         y_valid
);

  if (N < DEC_N_MIN || N > DEC_N_MAX) begin : g_bad_n
    $fatal(1, "decoder: N=%0d outside legal range %0d..%0d", N, DEC_N_MIN, DEC_N_MAX);
  end

  logic [M-1:0] dec;
  logic [M-1:0] y_q;
  logic         valid_q;

  decoder_core #(.N(N)) u_core (
    .d      (d),
    .onehot (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end
`ifdef DECODER_HOLD_EN
    else if (en) begin
      y_q     <= dec;
      valid_q <= 1'b1;
    end
`else
    else begin
      y_q     <= en ? dec : '0;
      valid_q <= en;
    end
`endif
  end

  // Inversion sits after the register so reset shows all ones when active-low.
  assign y       = ACTIVE_LOW ? ~y_q : y_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: three instances (N=2, N=2 active-low, N=3) share stimulus
// and are compared every cycle against a behavioural model, plus literal directed checks.
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] d3;

  logic [3:0] y;
  logic       yv;
  logic [3:0] y_low;
  logic       yv_low;
  logic [7:0] y_wide;
  logic       yv_wide;

  int total = 0;
  int bad   = 0;

  bit exp_on    = 1'b0;
  int exp_code  = 0;
  bit exp_valid = 1'b0;
  bit chk_on    = 1'b0;

  always #5 clk = ~clk;

  decoder #(.N(2), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .d(d3[1:0]), .en(en), .y(y), .y_valid(yv)
  );

  decoder #(.N(2), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .d(d3[1:0]), .en(en), .y(y_low), .y_valid(yv_low)
  );

  decoder #(.N(3), .ACTIVE_LOW(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n), .d(d3), .en(en), .y(y_wide), .y_valid(yv_wide)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected active-high output for a decoder of width w, from the model state.
  function automatic logic [7:0] exp_y(input int w);
    if (!exp_on) return 8'h00;
    return 8'(1 << (exp_code % w));
  endfunction

  // Advance one clock: capture what the edge sampled into the model, then settle.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
`ifdef DECODER_HOLD_EN
      if (en) begin
        exp_on    = 1'b1;
        exp_code  = int'(d3);
        exp_valid = 1'b1;
      end
`else
      exp_on    = en;
      exp_code  = int'(d3);
      exp_valid = en;
`endif
    end
    #2;
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    exp_on    = 1'b0;
    exp_valid = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    logic [7:0] e4;
    logic [7:0] e8;
    if (chk_on) begin
      e4 = exp_y(4);
      e8 = exp_y(8);
      check("y",             8'(y),            e4);
      check("y_valid",       8'(yv),           8'(exp_valid));
      check("y_low",         8'(y_low),        {4'h0, ~e4[3:0]});
      check("y_valid_low",   8'(yv_low),       8'(exp_valid));
      check("y_wide",        y_wide,           e8);
      check("y_valid_wide",  8'(yv_wide),      8'(exp_valid));
      check("onehot_or_zero", 8'($countones(y_wide) <= 1), 8'd1);
    end
  end

  initial begin
    logic [3:0] sweep_exp [4];
    sweep_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    en = 1'b0;
    d3 = 3'd0;
    assert_reset();
    chk_on = 1'b1;

    #1;
    check("reset_y",      8'(y),     8'h00);
    check("reset_y_low",  8'(y_low), 8'h0F);
    check("reset_valid",  8'(yv),    8'h00);

    cycle();
    cycle();
    rst_n = 1'b1;

    // Sweep every code back to back
    for (int i = 0; i < 4; i++) begin
      d3 = 3'(i);
      en = 1'b1;
      cycle();
      check("sweep_y",     8'(y),  8'(sweep_exp[i]));
      check("sweep_valid", 8'(yv), 8'h01);
    end

    // Asynchronous reset in the middle of a cycle
    d3 = 3'd2;
    en = 1'b1;
    cycle();
    check("pre_reset_y", 8'(y), 8'b0000_0100);
    #1;
    assert_reset();
    #1;
    check("async_reset_y",     8'(y),     8'h00);
    check("async_reset_valid", 8'(yv),    8'h00);
    check("async_reset_low",   8'(y_low), 8'h0F);
    cycle();
    rst_n = 1'b1;

    // Enable low after a decode
    d3 = 3'd2;
    en = 1'b1;
    cycle();
    check("en_hi_y", 8'(y), 8'b0000_0100);
    en = 1'b0;
    cycle();
`ifdef DECODER_HOLD_EN
    check("en_lo_y",     8'(y),  8'b0000_0100);
    check("en_lo_valid", 8'(yv), 8'h01);
`else
    check("en_lo_y",     8'(y),  8'h00);
    check("en_lo_valid", 8'(yv), 8'h00);
`endif

    // Active-low polarity
    d3 = 3'd1;
    en = 1'b1;
    cycle();
    check("polarity_y_low", 8'(y_low), 8'b0000_1101);

    // Wider select
    d3 = 3'd7;
    en = 1'b1;
    cycle();
    check("wide_y",   y_wide, 8'b1000_0000);
    check("narrow_y", 8'(y),  8'b0000_1000);

    // Random d/en with occasional mid-cycle resets
    for (int k = 0; k < 1000; k++) begin
      d3 = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) begin
        #1;
        assert_reset();
      end
      cycle();
      if (!rst_n) rst_n = 1'b1;
    end

    cycle();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
